// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle CPU control FSM: sequences IF/ID/EX/MEM/WB phases and drives datapath selects.
// Optional feature: define MC_CTRL_JUMP_EN to build the JMP state for op 000010.
module multi_cycle_ctrl (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  input  logic       mem_ready_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       iord_o,
  output logic       ir_write_o,
  output logic       pc_write_o,
  output logic [1:0] pc_src_o,
  output logic       reg_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic [1:0] alu_src_a_o,
  output logic [1:0] alu_src_b_o,
  output logic       imm_zext_o,
  output logic [3:0] alu_ctrl_o,
  output logic       instr_done_o,
  output logic       illegal_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_IF       = 4'd0,
    S_ID       = 4'd1,
    S_EX_R     = 4'd2,
    S_EX_I     = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WR   = 4'd6,
    S_WB_R     = 4'd7,
    S_WB_I     = 4'd8,
    S_WB_MEM   = 4'd9,
    S_BR       = 4'd10,
`ifdef MC_CTRL_JUMP_EN
    S_JMP      = 4'd11,
`endif
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
`ifdef MC_CTRL_JUMP_EN
  localparam logic [5:0] OP_J     = 6'b000010;
`endif

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_SLL = 4'b1000;
  localparam logic [3:0] ALU_SRL = 4'b1001;

  state_t state_q, state_d;
  logic   illegal_q, illegal_d;
  logic   funct_legal;
  logic   ir_we, pc_we, reg_we, mem_we;

  always_comb begin
    case (funct_i)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
      6'b000100, 6'b000110, 6'b000000, 6'b000010: funct_legal = 1'b1;
      default:                                   funct_legal = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IF:       if (mem_ready_i) state_d = S_ID;
      S_ID: begin
        case (op_i)
          OP_RTYPE:        state_d = funct_legal ? S_EX_R : S_TRAP;
          OP_ADDI, OP_ORI: state_d = S_EX_I;
          OP_LW, OP_SW:    state_d = S_MEM_ADDR;
          OP_BEQ:          state_d = S_BR;
`ifdef MC_CTRL_JUMP_EN
          OP_J:            state_d = S_JMP;
`endif
          default:         state_d = S_TRAP;
        endcase
      end
      S_EX_R:     state_d = S_WB_R;
      S_EX_I:     state_d = S_WB_I;
      S_MEM_ADDR: state_d = (op_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   if (mem_ready_i) state_d = S_WB_MEM;
      S_MEM_WR:   if (mem_ready_i) state_d = S_IF;
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_IF;
    endcase
  end

  // Sticky flag set on the transition into TRAP, so it rises together with state_o=12.
  assign illegal_d = illegal_q | (state_d == S_TRAP);

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IF;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    mem_req_o    = 1'b0;
    mem_we       = 1'b0;
    iord_o       = 1'b0;
    ir_we        = 1'b0;
    pc_we        = 1'b0;
    pc_src_o     = 2'b00;
    reg_we       = 1'b0;
    reg_dst_o    = 1'b0;
    mem_to_reg_o = 1'b0;
    alu_src_a_o  = 2'b00;
    alu_src_b_o  = 2'b00;
    imm_zext_o   = 1'b0;
    alu_ctrl_o   = ALU_AND;
    instr_done_o = 1'b0;
    case (state_q)
      S_IF: begin
        mem_req_o   = 1'b1;
        alu_src_b_o = 2'b01;
        alu_ctrl_o  = ALU_ADD;
        ir_we       = mem_ready_i;
        pc_we       = mem_ready_i;
      end
      S_ID: begin
        alu_src_b_o = 2'b11;
        alu_ctrl_o  = ALU_ADD;
      end
      S_EX_R: begin
        alu_src_a_o = 2'b01;
        case (funct_i)
          6'b100000: alu_ctrl_o = ALU_ADD;
          6'b100010: alu_ctrl_o = ALU_SUB;
          6'b100100: alu_ctrl_o = ALU_AND;
          6'b100101: alu_ctrl_o = ALU_OR;
          6'b101010: alu_ctrl_o = ALU_SLT;
          6'b000100: alu_ctrl_o = ALU_SLL;
          6'b000110: alu_ctrl_o = ALU_SRL;
          6'b000000: begin alu_src_a_o = 2'b10; alu_ctrl_o = ALU_SLL; end
          6'b000010: begin alu_src_a_o = 2'b10; alu_ctrl_o = ALU_SRL; end
          default:   alu_ctrl_o = ALU_AND;
        endcase
      end
      S_EX_I: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        imm_zext_o  = (op_i == OP_ORI);
        alu_ctrl_o  = (op_i == OP_ORI) ? ALU_OR : ALU_ADD;
      end
      S_MEM_ADDR: begin
        alu_src_a_o = 2'b01;
        alu_src_b_o = 2'b10;
        alu_ctrl_o  = ALU_ADD;
      end
      S_MEM_RD: begin
        mem_req_o = 1'b1;
        iord_o    = 1'b1;
      end
      S_MEM_WR: begin
        mem_req_o    = 1'b1;
        mem_we       = 1'b1;
        iord_o       = 1'b1;
        instr_done_o = mem_ready_i;
      end
      S_WB_R: begin
        reg_we       = 1'b1;
        reg_dst_o    = 1'b1;
        instr_done_o = 1'b1;
      end
      S_WB_I: begin
        reg_we       = 1'b1;
        instr_done_o = 1'b1;
      end
      S_WB_MEM: begin
        reg_we       = 1'b1;
        mem_to_reg_o = 1'b1;
        instr_done_o = 1'b1;
      end
      S_BR: begin
        alu_src_a_o  = 2'b01;
        alu_ctrl_o   = ALU_SUB;
        pc_src_o     = 2'b01;
        pc_we        = zero_i;
        instr_done_o = 1'b1;
      end
`ifdef MC_CTRL_JUMP_EN
      S_JMP: begin
        pc_src_o     = 2'b10;
        pc_we        = 1'b1;
        instr_done_o = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  // Reset forces IF asynchronously; masking with rst_n keeps IF's Mealy writes quiet during reset.
  assign ir_write_o  = ir_we  & rst_n;
  assign pc_write_o  = pc_we  & rst_n;
  assign reg_write_o = reg_we & rst_n;
  assign mem_we_o    = mem_we & rst_n;
  assign illegal_o   = illegal_q;
  assign state_o     = state_q;

endmodule

// File: doc/multi_cycle_ctrl.md
# multi_cycle_ctrl

Main control FSM for the multi-cycle version of Simple_Single_CPU. The datapath shares one ALU and one unified memory port across instruction phases; this block sequences those phases and drives every datapath select and write-enable from the current opcode/funct. It also stalls on a ready/request memory handshake. It sits beside the IR/PC registers and replaces the combinational Decoder and ALU_Ctrl of the single-cycle design.

## Interface
- No parameters.
- clk_i  in  1  clock; all state changes on rising edge
- rst_n  in  1  asynchronous, active-low reset
- op_i  in  6  IR[31:26]
- funct_i  in  6  IR[5:0]
- zero_i  in  1  ALU zero flag, same cycle
- mem_ready_i  in  1  memory completes the current request this cycle
- mem_req_o  out  1  memory request
- mem_we_o  out  1  write (valid with mem_req_o)
- iord_o  out  1  address select: 0 = PC, 1 = ALUOut
- ir_write_o  out  1  load IR
- pc_write_o  out  1  load PC (unconditional or branch-qualified)
- pc_src_o  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- reg_write_o  out  1  register-file write
- reg_dst_o  out  1  0 = rt, 1 = rd
- mem_to_reg_o  out  1  0 = ALUOut, 1 = MDR
- alu_src_a_o  out  2  00 = PC, 01 = rs, 10 = shamt (zero-extended)
- alu_src_b_o  out  2  00 = rt, 01 = constant 4, 10 = extended imm, 11 = sign-extended imm<<2
- imm_zext_o  out  1  1 = zero-extend imm (ori), 0 = sign-extend
- alu_ctrl_o  out  4  AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, SLL 1000, SRL 1001 (shifts: B shifted by A[4:0])
- instr_done_o  out  1  one-cycle pulse in an instruction's final cycle
- illegal_o  out  1  sticky: illegal op/funct decoded
- state_o  out  4  current state encoding, for debug and verification

## Operation
- States and encodings: IF 0, ID 1, EX_R 2, EX_I 3, MEM_ADDR 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_MEM 9, BR 10, JMP 11, TRAP 12.
- All outputs not listed for a state are 0.
- IF:
  - mem_req_o=1, iord_o=0, alu A=PC, B=4, ADD, pc_src_o=00.
  - ir_write_o and pc_write_o = mem_ready_i (Mealy).
  - Go to ID on mem_ready_i=1, else stay in IF.
- ID:
  - A=PC, B=11, ADD (branch target latched into ALUOut).
  - Decode op: 000000 → EX_R if funct is legal, else TRAP.
  - 001000/001101 → EX_I; 100011/101011 → MEM_ADDR; 000100 → BR; 000010 → JMP (macro only); anything else → TRAP.
- EX_R:
  - funct 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT: A=01, B=00.
  - funct 000100 SLLV, 000110 SRLV: A=01, B=00, SLL/SRL.
  - funct 000000 SLL, 000010 SRL: A=10, B=00.
  - Next state WB_R.
- WB_R: reg_write_o=1, reg_dst_o=1, mem_to_reg_o=0, instr_done_o=1. Next state IF.
- EX_I: A=01, B=10, ADD for addi, OR with imm_zext_o=1 for ori. Next state WB_I.
- WB_I: reg_write_o=1, reg_dst_o=0, instr_done_o=1. Next state IF.
- MEM_ADDR: A=01, B=10, ADD. lw → MEM_RD, sw → MEM_WR.
- MEM_RD: mem_req_o=1, iord_o=1. Go to WB_MEM on mem_ready_i, else stay.
- MEM_WR: mem_req_o=1, mem_we_o=1, iord_o=1. On mem_ready_i, instr_done_o=1 and go to IF; else stay.
- WB_MEM: reg_write_o=1, reg_dst_o=0, mem_to_reg_o=1, instr_done_o=1. Next state IF.
- BR: A=01, B=00, SUB, pc_src_o=01, pc_write_o=zero_i, instr_done_o=1. Next state IF.
- JMP: pc_src_o=10, pc_write_o=1, instr_done_o=1. Next state IF.
- TRAP: illegal_o=1, no requests or writes. Exit only through reset.

## Timing
- Reset: state=IF asynchronously. illegal_o=0. Outputs are the IF decode: mem_req_o=1, alu_src_b_o=01, alu_ctrl_o=0010, all others 0.
- Latency with mem_ready_i held at 1:
  - R-type, addi, ori, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, j: 3 cycles.
- Each low cycle of mem_ready_i in IF, MEM_RD or MEM_WR adds one cycle. Outputs hold steady while stalled.
- mem_ready_i is ignored outside IF, MEM_RD and MEM_WR.
- instr_done_o is never asserted in IF, ID or TRAP, and is never high for two consecutive cycles.
- rst_n falling mid-instruction (any state) aborts immediately. No write-enable may be asserted while rst_n=0.

## Configuration
- MC_CTRL_JUMP_EN defined: op 000010 goes ID → JMP → IF.
- MC_CTRL_JUMP_EN undefined: JMP state is not built, and op 000010 is illegal (ID → TRAP).

## Test plan
- add (op 000000, funct 100000), mem_ready_i=1 → state_o 0,1,2,7,0. In state 7: reg_write_o=1, reg_dst_o=1, instr_done_o=1.
- IF with mem_ready_i low for 3 cycles → state_o=0 for 4 cycles. ir_write_o and pc_write_o are high only in the 4th cycle.
- beq, zero_i=1 → BR at cycle 3 with pc_write_o=1, pc_src_o=01. With zero_i=0, pc_write_o=0 and instr_done_o=1 regardless.
- lw with MEM_RD ready after 2 waits → states 0,1,4,5,5,5,9. WB_MEM asserts mem_to_reg_o=1.
- funct 000001 → ID → TRAP. illegal_o stays 1 for 20 cycles, then clears on rst_n=0.
- rst_n pulsed low during EX_I → state_o=0 in the same cycle, reg_write_o never asserted. Also run op 000010 with and without MC_CTRL_JUMP_EN → JMP vs TRAP.
